// File: rtl/streamer_pkg.sv
// Shared types and constants for the sorted-array streamer.
// Nothing here depends on the STREAMER_ORDER_CHECK_EN macro.
package streamer_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] SIZE_ADDR = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SIZE,
    ST_LATCH_SIZE,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with push/pop/count/head.
// Reset is asynchronous active-low. DEPTH must be a power of two.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_idx_q];
  assign count_o = count_q;

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (do_push) wr_idx_d = wr_idx_q + 1'b1;
    if (do_pop)  rd_idx_d = rd_idx_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx_q] <= push_data_i;
  end

endmodule

// File: rtl/sorted_array_streamer.sv
// Reads N from address 0 and elements 1..N from the shared memory, streams them out.
// Define STREAMER_ORDER_CHECK_EN to enable the sticky ordering check on sorted_ok.
module sorted_array_streamer
  import streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rdy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sorted_ok
);

  // state         | meaning
  // ST_IDLE       | rdy=1, waiting for start
  // ST_RD_SIZE    | address 0 presented to memory
  // ST_LATCH_SIZE | capture N, reset pointers and check state
  // ST_STREAM     | issue element reads while FIFO credit allows
  // ST_DRAIN      | all reads issued, wait for the Nth handshake
  // ST_FIN        | one-cycle done pulse

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [8:0]        rd_ptr_q, rd_ptr_d;
  logic [8:0]        out_cnt_q, out_cnt_d;
  logic              inflight_q;
  logic              issue;
  logic              hs;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic [8:0]        n_ext;
  logic [8:0]        last_idx;

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (rddata),
    .pop_i       (hs),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign n_ext     = {1'b0, n_q};
  assign last_idx  = n_ext - 9'd1;
  // Reads in flight already own a FIFO slot, so they count against the credit.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_last  = out_valid && (out_cnt_q == last_idx);
  assign hs        = out_valid && out_ready;
  assign rdy       = (state_q == ST_IDLE);
  assign done      = (state_q == ST_FIN);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rd_ptr_d  = rd_ptr_q;
    out_cnt_d = out_cnt_q;
    issue     = 1'b0;
    addr      = SIZE_ADDR;
    if (hs) out_cnt_d = out_cnt_q + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RD_SIZE;
      end
      ST_RD_SIZE: begin
        state_d = ST_LATCH_SIZE;
      end
      ST_LATCH_SIZE: begin
        n_d       = rddata;
        rd_ptr_d  = 9'd1;
        out_cnt_d = '0;
        state_d   = (rddata == '0) ? ST_FIN : ST_STREAM;
      end
      ST_STREAM: begin
        addr = rd_ptr_q[ADDR_W-1:0];
        if (rd_ptr_q > n_ext) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue    = 1'b1;
          rd_ptr_d = rd_ptr_q + 9'd1;
          if (rd_ptr_q == n_ext) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Reaching N handshakes implies the FIFO is empty and nothing is in flight.
        if (out_cnt_d == n_ext) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      rd_ptr_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_ptr_q   <= rd_ptr_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= issue;
    end
  end

`ifdef STREAMER_ORDER_CHECK_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              ok_q, ok_d;

  always_comb begin
    prev_d = prev_q;
    ok_d   = ok_q;
    if (state_q == ST_LATCH_SIZE) begin
      prev_d = '0;
      ok_d   = 1'b1;
    end else if (hs) begin
      prev_d = out_data;
      if ((out_cnt_q != '0) && (out_data < prev_q)) ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ok_q   <= 1'b1;
    end else begin
      prev_q <= prev_d;
      ok_q   <= ok_d;
    end
  end

  assign sorted_ok = ok_q;
`else
  assign sorted_ok = 1'b1;
`endif

endmodule

// File: tb/tb_sorted_array_streamer.sv
// Self-checking bench for sorted_array_streamer: memory model, random sink
// backpressure, and an array-based reference for stream content and timing.
module tb_sorted_array_streamer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rdy;
  logic       done;
  logic [7:0] addr;
  logic [7:0] rddata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       sorted_ok;

  sorted_array_streamer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rdy       (rdy),
    .done      (done),
    .addr      (addr),
    .rddata    (rddata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .sorted_ok (sorted_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) rddata <= mem[addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got_v, input int exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // sink / monitor state
  int   got[$];
  logic mon_en = 1'b0;
  int   ready_mode = 0;
  int   exp_n = 0;
  int   first_v_cyc, last_beat_cyc, done_cnt, done_cyc, ok_at_done;
  int   last_err, stab_err, wrap_err, seen_n, addr_win;
  logic prev_valid, prev_hs, prev_last, r_now, hs_now;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (!mon_en) begin
      out_ready  = 1'b1;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      r_now = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
      out_ready = r_now;
      if (prev_valid && !prev_hs)
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) stab_err++;
      if (out_valid) begin
        if (first_v_cyc < 0) first_v_cyc = cyc;
        if (out_last !== (got.size() == exp_n - 1)) last_err++;
      end
      hs_now = out_valid && r_now;
      if (hs_now) begin
        got.push_back(int'(out_data));
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        ok_at_done = int'(sorted_ok);
      end
      if (cyc >= addr_win && seen_n == 0) begin
        if (addr == 8'd0) wrap_err++;
        if (addr == exp_n[7:0]) seen_n = 1;
      end
      prev_valid = out_valid;
      prev_hs    = hs_now;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  function automatic int model_sorted_ok(input int n);
    int ok;
    ok = 1;
`ifdef STREAMER_ORDER_CHECK_EN
    for (int i = 2; i <= n; i++)
      if (mem[i] < mem[i-1]) ok = 0;
`endif
    return ok;
  endfunction

  task automatic clear_monitor(input int n, input int rmode);
    got.delete();
    first_v_cyc   = -1;
    last_beat_cyc = -1;
    done_cnt      = 0;
    done_cyc      = -1;
    ok_at_done    = -1;
    last_err      = 0;
    stab_err      = 0;
    wrap_err      = 0;
    seen_n        = 0;
    addr_win      = 1 << 30;
    exp_n         = n;
    ready_mode    = rmode;
    mem[0]        = n[7:0];
  endtask

  task automatic run_pass(input string name, input int n, input int rmode, input int hold);
    int a;
    int budget;
    clear_monitor(n, rmode);
    @(negedge clk);
    mon_en = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 a = cyc;
    if (n > 0) addr_win = a + 2;
    if (hold == 0) begin
      @(negedge clk);
      start = 1'b0;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(negedge clk);
      #1 budget++;
      if (budget == 4) start = 1'b0;
    end
    start = 1'b0;
    check_eq({name, ":done_seen"}, int'(done_cnt > 0), 1);
    @(negedge clk);
    #1 check_eq({name, ":rdy_after_done"}, int'(rdy), 1);
    repeat (6) @(negedge clk);
    #1 mon_en = 1'b0;

    check_eq({name, ":beat_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check_eq($sformatf("%s:beat%0d", name, i), got[i], int'(mem[i+1]));
    check_eq({name, ":last_flag"}, last_err, 0);
    check_eq({name, ":stall_stable"}, stab_err, 0);
    check_eq({name, ":done_pulses"}, done_cnt, 1);
    check_eq({name, ":sorted_ok"}, ok_at_done, model_sorted_ok(n));
    if (n > 0) begin
      check_eq({name, ":addr_no_wrap"}, wrap_err, 0);
      check_eq({name, ":addr_reached_n"}, seen_n, 1);
    end
    if (rmode == 0) begin
      if (n == 0) begin
        check_eq({name, ":done_cycle"}, done_cyc, a + 2);
        check_eq({name, ":no_valid"}, first_v_cyc, -1);
      end else begin
        check_eq({name, ":first_valid"}, first_v_cyc, a + 4);
        check_eq({name, ":last_beat"}, last_beat_cyc, a + n + 3);
        check_eq({name, ":done_cycle"}, done_cyc, a + n + 4);
      end
    end
  endtask

  initial begin
    int budget;
    int n;
    int v;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    clear_monitor(0, 0);

    #12;
    check_eq("rst:rdy", int'(rdy), 1);
    check_eq("rst:done", int'(done), 0);
    check_eq("rst:addr", int'(addr), 0);
    check_eq("rst:out_valid", int'(out_valid), 0);
    check_eq("rst:out_last", int'(out_last), 0);
    check_eq("rst:out_data", int'(out_data), 0);
    check_eq("rst:sorted_ok", int'(sorted_ok), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass("empty", 0, 0, 0);

    mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd3; mem[4] = 8'd7; mem[5] = 8'd9;
    run_pass("five_full", 5, 0, 0);
    run_pass("five_stall", 5, 1, 0);

    mem[1] = 8'd3; mem[2] = 8'd8; mem[3] = 8'd2; mem[4] = 8'd9;
    run_pass("unsorted", 4, 1, 0);

    for (int k = 1; k <= 255; k++) mem[k] = 8'(k - 1);
    run_pass("n255", 255, 0, 0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 24);
      v = 0;
      for (int k = 1; k <= n; k++) begin
        if (t % 2 == 0) begin
          v = v + $urandom_range(0, 10);
          if (v > 255) v = 255;
          mem[k] = 8'(v);
        end else begin
          mem[k] = 8'($urandom_range(0, 255));
        end
      end
      run_pass($sformatf("rand%0d", t), n, t % 3 == 0 ? 0 : 1, 0);
    end

    // abort after the third beat, then a fresh pass with start held high
    for (int k = 1; k <= 6; k++) mem[k] = 8'(10 * k);
    clear_monitor(6, 0);
    @(negedge clk);
    mon_en = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    budget = 0;
    while (got.size() < 3 && budget < 200) begin
      @(negedge clk);
      #1 budget++;
    end
    check_eq("abort:reached_beat3", got.size(), 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_eq("abort:out_valid", int'(out_valid), 0);
    check_eq("abort:out_last", int'(out_last), 0);
    check_eq("abort:rdy", int'(rdy), 1);
    check_eq("abort:done", int'(done), 0);
    for (int i = 0; i < 3 && i < got.size(); i++)
      check_eq($sformatf("abort:beat%0d", i), got[i], 10 * (i + 1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort:idle_no_valid", int'(out_valid), 0);

    mem[1] = 8'd40; mem[2] = 8'd41;
    run_pass("after_abort_hold", 2, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
